// File: rtl/lwe_pkg.sv
// lwe_pkg: shared modulus constants, coefficient type, encryption FSM states and modular add
package lwe_pkg;
  localparam int COEFF_WIDTH = 12;
  localparam int Q = 3329;
  localparam int HALF_Q = Q / 2;
  typedef logic [COEFF_WIDTH-1:0] coeff_t;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, FINAL, OUT} enc_state_t;
  function automatic logic [31:0] mod_add(input logic [31:0] x, input logic [31:0] y, input logic [31:0] q);
    return (x + y >= q) ? x + y - q : x + y;
  endfunction
endpackage

// File: rtl/lwe_mod_add.sv
// lwe_mod_add: combinational (a+b) mod Q for operands already below Q
module lwe_mod_add #(
  parameter int WIDTH = 12,
  parameter int Q = 3329
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);
  logic [WIDTH:0] t;
  assign t = {1'b0, a} + {1'b0, b};
  assign s = (t >= (WIDTH+1)'(Q)) ? WIDTH'(t - (WIDTH+1)'(Q)) : t[WIDTH-1:0];
endmodule

// File: rtl/lwe_encrypt_accumulator.sv
// lwe_encrypt_accumulator: streams the key cache and sums a row subset mod Q into (u, v); LWE_ENC_INTERNAL_LFSR_EN picks rows with an internal LFSR
module lwe_encrypt_accumulator #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_COLS = 4,
  parameter int NUM_ROWS = 1024,
  parameter int SUM_WIDTH = 16,
  parameter int Q = 3329
`ifdef LWE_ENC_INTERNAL_LFSR_EN
  , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     kyber_k,
  input  logic                           start,
  input  logic                           msg_bit,
  input  logic                           sel_bit,
  output logic                           busy,
  output logic                           cache_rd_req,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] cache_row,
  input  logic [SUM_WIDTH-1:0]           cache_sum,
  output logic [NUM_COLS*DATA_WIDTH-1:0] ct_u,
  output logic [SUM_WIDTH-1:0]           ct_v,
  output logic                           ct_valid,
  input  logic                           ct_ready
);
  import lwe_pkg::*;
  localparam int CW = $clog2(NUM_ROWS);
  localparam logic [SUM_WIDTH-1:0] HALF = SUM_WIDTH'(Q / 2);
  enc_state_t state, state_n;
  logic [CW-1:0] rd_cnt;
  logic dv, msg, k3, sel, last;
  logic [DATA_WIDTH-1:0] u [NUM_COLS];
  logic [DATA_WIDTH-1:0] u_sum [NUM_COLS];
  logic [SUM_WIDTH-1:0] v, v_add, v_sum;
  assign last = rd_cnt == CW'(NUM_ROWS - 1);
  assign cache_rd_req = state == FETCH;
  assign busy = state != IDLE;
  assign ct_v = v;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? FETCH :
              (state == FETCH && last) ? DRAIN :
              (state == DRAIN) ? FINAL :
              (state == FINAL) ? OUT :
              (state == OUT && ct_valid && ct_ready) ? IDLE : state;
  end
`ifdef LWE_ENC_INTERNAL_LFSR_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else if (dv) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign sel = lfsr[0];
`else
  assign sel = sel_bit;
`endif
  // The v adder doubles as the message encoder in FINAL.
  assign v_add = (state == FINAL) ? (msg ? HALF : '0) : cache_sum;
  lwe_mod_add #(.WIDTH(SUM_WIDTH), .Q(Q)) v_adder (.a(v), .b(v_add), .s(v_sum));
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    lwe_mod_add #(.WIDTH(DATA_WIDTH), .Q(Q)) u_adder (
      .a(u[c]), .b(cache_row[c*DATA_WIDTH +: DATA_WIDTH]), .s(u_sum[c]));
    assign ct_u[c*DATA_WIDTH +: DATA_WIDTH] = u[c];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      dv <= 1'b0;
      msg <= 1'b0;
      k3 <= 1'b0;
      v <= '0;
      ct_valid <= 1'b0;
      for (int j = 0; j < NUM_COLS; j++) u[j] <= '0;
    end else begin
      dv <= cache_rd_req;
      if (state == IDLE && start) begin
        msg <= msg_bit;
        k3 <= kyber_k == 3'd3;
        rd_cnt <= '0;
        v <= '0;
        for (int j = 0; j < NUM_COLS; j++) u[j] <= '0;
      end
      if (state == FETCH && !last) rd_cnt <= rd_cnt + 1'b1;
      if (dv && sel) begin
        v <= v_sum;
        for (int j = 0; j < NUM_COLS; j++) if (j != 3 || !k3) u[j] <= u_sum[j];
      end
      if (state == FINAL) begin
        v <= v_sum;
        ct_valid <= 1'b1;
      end
      if (ct_valid && ct_ready) ct_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lwe_encrypt_accumulator.sv
// tb_lwe_encrypt_accumulator: vector table plus ciphertext scoreboard against a 1-cycle cache model, NUM_ROWS=4
module tb_lwe_encrypt_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, msg_bit = 1'b0, sel_bit, ct_ready = 1'b1;
  logic busy, cache_rd_req, ct_valid;
  logic [2:0] kyber_k = 3'd4;
  logic [47:0] cache_row, ct_u;
  logic [15:0] cache_sum, ct_v;
  typedef struct {
    logic [2:0] k;
    logic msg;
    logic [3:0] sel;
    logic [3:0][47:0] row;
    logic [3:0][15:0] sum;
    logic [47:0] eu;
    logic [15:0] ev;
  } vec_t;
  typedef struct { logic [47:0] u; logic [15:0] v; } exp_t;
  exp_t exp_q[$];
  vec_t vecs[5];
  logic [47:0] mem_row[4];
  logic [15:0] mem_sum[4];
  logic [1:0] ptr, out_idx;
  logic [3:0] sel_pat = 4'b0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  lwe_encrypt_accumulator #(.NUM_ROWS(4)) dut (
    .clk(clk), .rst(rst), .kyber_k(kyber_k), .start(start), .msg_bit(msg_bit),
    .sel_bit(sel_bit), .busy(busy), .cache_rd_req(cache_rd_req), .cache_row(cache_row),
    .cache_sum(cache_sum), .ct_u(ct_u), .ct_v(ct_v), .ct_valid(ct_valid), .ct_ready(ct_ready));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
      out_idx <= 2'd0;
      cache_row <= '0;
      cache_sum <= '0;
    end else if (cache_rd_req) begin
      cache_row <= mem_row[ptr];
      cache_sum <= mem_sum[ptr];
      out_idx <= ptr;
      ptr <= ptr + 2'd1;
    end
  end
  assign sel_bit = sel_pat[out_idx];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && ct_valid && ct_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_ct", 64'(ct_v), 64'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("sb_u", 64'(ct_u), 64'(e.u));
        check("sb_v", 64'(ct_v), 64'(e.v));
      end
    end
  end
  function automatic logic [47:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
  endfunction
  function automatic vec_t mk(input int k, input logic msg, input logic [3:0] sel,
      input logic [47:0] r0, input logic [47:0] r1, input logic [47:0] r2, input logic [47:0] r3,
      input int s0, input int s1, input int s2, input int s3, input logic [47:0] eu, input int ev);
    vec_t t;
    t.k = 3'(k);
    t.msg = msg;
    t.sel = sel;
    t.row = {r3, r2, r1, r0};
    t.sum = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    t.eu = eu;
    t.ev = 16'(ev);
    return t;
  endfunction
  task automatic load(input vec_t t);
    for (int r = 0; r < 4; r++) begin
      mem_row[r] = t.row[r];
      mem_sum[r] = t.sum[r];
    end
    sel_pat = t.sel;
    kyber_k = t.k;
    msg_bit = t.msg;
    exp_q.push_back('{t.eu, t.ev});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic run_vec(input vec_t t, input string name);
    int n;
    load(t);
    n = 1;
    check({name, "_busy"}, 64'(busy), 64'd1);
    while (!ct_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'd7);
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    vecs[0] = mk(4, 1'b0, 4'b1111, pk(1,2,3,4), pk(1,2,3,4), pk(1,2,3,4), pk(1,2,3,4),
                 10, 10, 10, 10, pk(4,8,12,16), 40);
    vecs[1] = mk(4, 1'b1, 4'b1111, pk(3328,3328,3328,3328), pk(3328,3328,3328,3328),
                 pk(3328,3328,3328,3328), pk(3328,3328,3328,3328),
                 3000, 3000, 3000, 3000, pk(3325,3325,3325,3325), 348);
    vecs[2] = mk(3, 1'b0, 4'b0101, pk(5,5,5,5), pk(5,5,5,5), pk(5,5,5,5), pk(5,5,5,5),
                 7, 7, 7, 7, pk(10,10,10,0), 14);
    vecs[3] = mk(5, 1'b1, 4'b1011, pk(100,200,300,400), pk(3000,3000,3000,3000),
                 pk(1,1,1,1), pk(329,329,329,329), 1000, 2000, 3000, 100,
                 pk(100,200,300,400), 1435);
    vecs[4] = mk(3, 1'b1, 4'b1111, pk(1,1,1,1), pk(1,1,1,1), pk(1,1,1,1), pk(1,1,1,1),
                 0, 0, 0, 0, pk(4,4,4,0), 1664);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'(cache_rd_req), 64'd0);
    check("rst_valid", 64'(ct_valid), 64'd0);
    check("rst_u", 64'(ct_u), 64'd0);
    check("rst_v", 64'(ct_v), 64'd0);
`ifdef LWE_ENC_INTERNAL_LFSR_EN
    run_vec(mk(4, 1'b0, 4'b0000, 48'd0, 48'd0, 48'd0, 48'd0, 1, 1, 1, 1, 48'd0, 1), "lfsr");
`else
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    ct_ready = 1'b0;
    load(vecs[0]);
    n = 1;
    while (!ct_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_latency", 64'(n), 64'd7);
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", 64'(ct_valid), 64'd1);
      check("hold_u", 64'(ct_u), 64'(pk(4,8,12,16)));
      check("hold_v", 64'(ct_v), 64'd40);
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_no_req", 64'(cache_rd_req), 64'd0);
      start = (c == 2);
      @(posedge clk); #1;
      start = 1'b0;
    end
    ct_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("hs_busy", 64'(busy), 64'd0);
    check("hs_valid", 64'(ct_valid), 64'd0);
    check("hs_u_kept", 64'(ct_u), 64'(pk(4,8,12,16)));
    check("hs_v_kept", 64'(ct_v), 64'd40);
    @(posedge clk); #1;
    check("hs_start_ignored", 64'(busy), 64'd0);
    check("hs_no_req", 64'(cache_rd_req), 64'd0);
`endif
    load(vecs[0]);
    repeat (2) @(posedge clk);
    check("mid_req", 64'(cache_rd_req), 64'd1);
    #3 rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_req", 64'(cache_rd_req), 64'd0);
    check("abort_valid", 64'(ct_valid), 64'd0);
    check("abort_u", 64'(ct_u), 64'd0);
    check("abort_v", 64'(ct_v), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", 64'(busy), 64'd0);
`ifndef LWE_ENC_INTERNAL_LFSR_EN
    run_vec(vecs[3], "recover");
`endif
    repeat (2) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
